// File: rtl/aclk_time_counter.sv
// 24-hour BCD HH:MM time-of-day counter driven by minute ticks, with validated loads.
// Optional seconds counter enabled by defining ACLK_TCNT_SECONDS_EN.
module aclk_time_counter #(
    parameter logic [7:0] RST_HH = 8'h00,
    parameter logic [7:0] RST_MM = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_minute,
    input  logic       one_second,
    input  logic       load_time,
    input  logic [3:0] new_h1,
    input  logic [3:0] new_h0,
    input  logic [3:0] new_m1,
    input  logic [3:0] new_m0,
    output logic       reset_count,
    output logic [3:0] cur_h1,
    output logic [3:0] cur_h0,
    output logic [3:0] cur_m1,
    output logic [3:0] cur_m0,
    output logic [3:0] cur_s1,
    output logic [3:0] cur_s0,
    output logic       load_err,
    output logic       day_tick
);

    logic       load_ok;
    logic [3:0] n_h1, n_h0, n_m1, n_m0;
    logic       n_rc, n_le, n_dt;

    always_comb begin
        load_ok = (new_h1 <= 4'd2) && (new_h0 <= 4'd9) &&
                  (new_m1 <= 4'd5) && (new_m0 <= 4'd9) &&
                  !((new_h1 == 4'd2) && (new_h0 > 4'd3));
    end

`ifdef ACLK_TCNT_SECONDS_EN
    logic [3:0] s1, s0, n_s1, n_s0;
    assign cur_s1 = s1;
    assign cur_s0 = s0;
`else
    assign cur_s1 = 4'd0;
    assign cur_s0 = 4'd0;
`endif

    always_comb begin
        n_h1 = cur_h1;
        n_h0 = cur_h0;
        n_m1 = cur_m1;
        n_m0 = cur_m0;
        n_rc = 1'b0;
        n_le = 1'b0;
        n_dt = 1'b0;
`ifdef ACLK_TCNT_SECONDS_EN
        n_s1 = s1;
        n_s0 = s0;
`endif
        if (load_time && load_ok) begin
            // Accepted load wins over a coincident minute tick
            n_h1 = new_h1;
            n_h0 = new_h0;
            n_m1 = new_m1;
            n_m0 = new_m0;
            n_rc = 1'b1;
`ifdef ACLK_TCNT_SECONDS_EN
            n_s1 = 4'd0;
            n_s0 = 4'd0;
`endif
        end else begin
            n_le = load_time;
            if (one_minute) begin
`ifdef ACLK_TCNT_SECONDS_EN
                n_s1 = 4'd0;
                n_s0 = 4'd0;
`endif
                if (cur_m0 != 4'd9) begin
                    n_m0 = cur_m0 + 4'd1;
                end else begin
                    n_m0 = 4'd0;
                    if (cur_m1 != 4'd5) begin
                        n_m1 = cur_m1 + 4'd1;
                    end else begin
                        n_m1 = 4'd0;
                        if (cur_h1 == 4'd2 && cur_h0 == 4'd3) begin
                            n_h1 = 4'd0;
                            n_h0 = 4'd0;
                            n_dt = 1'b1;
                        end else if (cur_h0 == 4'd9) begin
                            n_h0 = 4'd0;
                            n_h1 = cur_h1 + 4'd1;
                        end else begin
                            n_h0 = cur_h0 + 4'd1;
                        end
                    end
                end
            end
`ifdef ACLK_TCNT_SECONDS_EN
            else if (one_second) begin
                if (s0 != 4'd9) begin
                    n_s0 = s0 + 4'd1;
                end else begin
                    n_s0 = 4'd0;
                    n_s1 = (s1 == 4'd5) ? 4'd0 : s1 + 4'd1;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_h1      <= RST_HH[7:4];
            cur_h0      <= RST_HH[3:0];
            cur_m1      <= RST_MM[7:4];
            cur_m0      <= RST_MM[3:0];
            reset_count <= 1'b0;
            load_err    <= 1'b0;
            day_tick    <= 1'b0;
        end else begin
            cur_h1      <= n_h1;
            cur_h0      <= n_h0;
            cur_m1      <= n_m1;
            cur_m0      <= n_m0;
            reset_count <= n_rc;
            load_err    <= n_le;
            day_tick    <= n_dt;
        end
    end

`ifdef ACLK_TCNT_SECONDS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 4'd0;
            s0 <= 4'd0;
        end else begin
            s1 <= n_s1;
            s0 <= n_s0;
        end
    end
`endif

endmodule

// File: tb/tb_aclk_time_counter.sv
// Randomised and directed bench for aclk_time_counter against a
// minute-of-day / seconds arithmetic model.
module tb_aclk_time_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       one_minute, one_second, load_time;
    logic [3:0] new_h1, new_h0, new_m1, new_m0;
    logic       reset_count, load_err, day_tick;
    logic [3:0] cur_h1, cur_h0, cur_m1, cur_m0, cur_s1, cur_s0;

    int errors = 0;
    int checks = 0;

    int tod;
    int sec;
    logic e_rc, e_le, e_dt;

    localparam int RST_TOD = 12 * 60 + 34;

    aclk_time_counter #(.RST_HH(8'h12), .RST_MM(8'h34)) dut (
        .clk(clk), .reset(reset),
        .one_minute(one_minute), .one_second(one_second),
        .load_time(load_time),
        .new_h1(new_h1), .new_h0(new_h0), .new_m1(new_m1), .new_m0(new_m0),
        .reset_count(reset_count),
        .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
        .cur_s1(cur_s1), .cur_s0(cur_s0),
        .load_err(load_err), .day_tick(day_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int t);
        int h, m;
        h = t / 60;
        m = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".time"}, {16'd0, cur_h1, cur_h0, cur_m1, cur_m0},
              {16'd0, to_bcd(tod)});
        check({tag, ".sec"}, {24'd0, cur_s1, cur_s0},
              {24'd0, 4'(sec / 10), 4'(sec % 10)});
        check({tag, ".pulse"}, {29'd0, reset_count, load_err, day_tick},
              {29'd0, e_rc, e_le, e_dt});
    endtask

    task automatic model(input logic lt, input logic om, input logic os,
                         input int h1, input int h0, input int m1, input int m0);
        bit ok;
        ok = h1 <= 9 && h0 <= 9 && m1 <= 9 && m0 <= 9 &&
             (h1 * 10 + h0) <= 23 && (m1 * 10 + m0) <= 59;
        e_rc = 1'b0;
        e_le = 1'b0;
        e_dt = 1'b0;
        if (lt && ok) begin
            tod = (h1 * 10 + h0) * 60 + m1 * 10 + m0;
            sec = 0;
            e_rc = 1'b1;
        end else begin
            e_le = lt;
            if (om) begin
                if (tod == 1439) e_dt = 1'b1;
                tod = (tod + 1) % 1440;
                sec = 0;
            end else if (os) begin
`ifdef ACLK_TCNT_SECONDS_EN
                sec = (sec + 1) % 60;
`endif
            end
        end
    endtask

    task automatic step(input string tag, input logic lt, input logic om,
                        input logic os, input int h1, input int h0,
                        input int m1, input int m0);
        load_time  = lt;
        one_minute = om;
        one_second = os;
        new_h1 = 4'(h1);
        new_h0 = 4'(h0);
        new_m1 = 4'(m1);
        new_m0 = 4'(m0);
        @(posedge clk);
        #1;
        model(lt, om, os, h1, h0, m1, m0);
        compare_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    int dt_count;

    initial begin
        reset = 1'b1;
        load_time = 1'b0;
        one_minute = 1'b0;
        one_second = 1'b0;
        {new_h1, new_h0, new_m1, new_m0} = 16'h0000;
        tod = RST_TOD;
        sec = 0;
        e_rc = 1'b0;
        e_le = 1'b0;
        e_dt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        reset = 1'b0;
        idle("post_reset");

        step("ld0959", 1'b1, 1'b0, 1'b0, 0, 9, 5, 9);
        step("min1000", 1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
        step("ld2359", 1'b1, 1'b0, 1'b0, 2, 3, 5, 9);
        step("wrap", 1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
        idle("wrap_after");

        step("bad2400", 1'b1, 1'b0, 1'b0, 2, 4, 0, 0);
        step("bad1260", 1'b1, 1'b0, 1'b0, 1, 2, 6, 0);
        step("bad1A00", 1'b1, 1'b0, 1'b0, 1, 10, 0, 0);
        step("bad_min", 1'b1, 1'b1, 1'b0, 3, 0, 0, 0);
        idle("bad_after");

        step("ld0715om", 1'b1, 1'b1, 1'b0, 0, 7, 1, 5);
        step("om_after_ld", 1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
        idle("ld_after");

        step("ld0000", 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        dt_count = 0;
        for (int i = 0; i < 1440; i++) begin
            step("fast", 1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
            if (day_tick) dt_count++;
        end
        check("fast_end", {16'd0, cur_h1, cur_h0, cur_m1, cur_m0}, 32'h0);
        check("fast_dt", dt_count, 1);

        for (int i = 0; i < 59; i++) step("sec", 1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
        step("sec_wrap", 1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
        for (int i = 0; i < 30; i++) step("sec30", 1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
        step("om_os", 1'b0, 1'b1, 1'b1, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            logic lt, om, os;
            int d[4];
            lt = ($urandom_range(0, 7) == 0);
            om = ($urandom_range(0, 3) == 0);
            os = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 1) == 0) begin
                for (int k = 0; k < 4; k++) d[k] = $urandom_range(0, 15);
            end else begin
                int h, m;
                h = $urandom_range(0, 23);
                m = $urandom_range(0, 59);
                d[0] = h / 10;
                d[1] = h % 10;
                d[2] = m / 10;
                d[3] = m % 10;
            end
            step("rand", lt, om, os, d[0], d[1], d[2], d[3]);
        end

        step("ld2359b", 1'b1, 1'b0, 1'b0, 2, 3, 5, 9);
        load_time = 1'b0;
        one_minute = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        tod = RST_TOD;
        sec = 0;
        e_rc = 1'b0;
        e_le = 1'b0;
        e_dt = 1'b0;
        compare_all("async_rst");
        @(posedge clk);
        #1;
        compare_all("rst_held");
        reset = 1'b0;
        idle("rst_release");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aclk_time_counter.md
# aclk_time_counter

Consumer of the alarm-clock minute/second tick pulses from the time generator. Maintains the current time-of-day as 24-hour BCD digits (HH:MM), advancing one minute per `one_minute` pulse. Accepts validated user time loads, and drives `reset_count` back to the time generator so the sub-minute phase restarts on every accepted load. Sits between the time generator and the display/alarm-compare logic.

## Interface
- `RST_HH`, default 8'h00: BCD hours loaded on reset; must be 00–23.
- `RST_MM`, default 8'h00: BCD minutes loaded on reset; must be 00–59.

- `clk`  in  1: clock
- `reset`  in  1: asynchronous, active-high reset
- `one_minute`  in  1: single-cycle minute tick from the time generator
- `one_second`  in  1: single-cycle second tick; used only with `ACLK_TCNT_SECONDS_EN`
- `load_time`  in  1: single-cycle request to load `new_*` digits
- `new_h1`, `new_h0`, `new_m1`, `new_m0`  in  4 each: BCD digits of the requested time
- `reset_count`  out  1: one-cycle pulse to the time generator after an accepted load
- `cur_h1`, `cur_h0`, `cur_m1`, `cur_m0`  out  4 each: current time digits, registered
- `cur_s1`, `cur_s0`  out  4 each: seconds digits; 0 when the feature is compiled out
- `load_err`  out  1: one-cycle pulse when a load is rejected
- `day_tick`  out  1: one-cycle pulse on the 23:59→00:00 wrap

## Operation
- Reset values:
  - Time outputs take `RST_HH`/`RST_MM`.
  - `cur_s1`/`cur_s0` = 0.
  - `reset_count`, `load_err`, `day_tick` = 0.
- Minute advance on `one_minute` (no load that cycle):
  - `cur_m0` +1.
  - 9→0 carries into `cur_m1`.
  - `cur_m1` 5→0 (59→00) carries into the hour.
  - Hour: `cur_h0` 9→0 carries into `cur_h1`.
  - Hour 23→00 on minute carry; asserts `day_tick` on that update.
- Load validation (combinational on `new_*`):
  - Every digit must be ≤9.
  - Also required: `new_h1` ≤2, `new_m1` ≤5, and if `new_h1`=2 then `new_h0` ≤3.
- Accepted load:
  - All four time digits take `new_*`.
  - Seconds are cleared.
  - `reset_count` pulses.
- Rejected load:
  - Time is unchanged.
  - `load_err` pulses; no `reset_count`.
  - A coincident `one_minute` is processed normally.
- Priority, highest first:
  1. `reset`
  2. Accepted `load_time`
  3. `one_minute`
  4. `one_second`
- An accepted load drops a coincident `one_minute` (no increment, no `day_tick`).
- Pulse outputs are never asserted for more than one cycle per event.
- Back-to-back loads each produce their own `reset_count`/`load_err` pulse.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- `one_minute` sampled high at edge N: digits show the new time after edge N. `day_tick` is high during cycle N→N+1.
- `load_time` sampled at edge N:
  - Digits and `load_err` update at edge N.
  - `reset_count` is high during cycle N→N+1, so the time generator clears its count at edge N+1.
  - A `one_minute` at edge N+1 is still honoured.
- Consecutive `one_minute` cycles (fast-watch mode) advance one minute per cycle with no loss.
- Asynchronous `reset` mid-operation forces the reset values immediately. Pending pulses are discarded.

## Configuration
- Macro: `ACLK_TCNT_SECONDS_EN`.
- Defined:
  - 00–59 BCD seconds counter advances on `one_second`, wrapping 59→00.
  - It does not carry into minutes; minutes advance only on `one_minute`.
  - `one_minute` clears seconds to 00, with priority over a coincident `one_second`.
  - An accepted load clears seconds.
  - `cur_s1`/`cur_s0` are driven from the counter.
- Undefined:
  - Seconds logic is absent; `cur_s1`/`cur_s0` are tied to 0.
  - `one_second` is ignored.

## Test plan
- Reset with `RST_HH`=8'h12, `RST_MM`=8'h34 → outputs 12:34, all pulse outputs 0.
- Load 09:59, then one `one_minute` → 10:00. Load 23:59, then `one_minute` → 00:00 with `day_tick` high exactly 1 cycle.
- Load 24:00, then 12:60, then 1A:00 → `load_err` pulses each time; time unchanged; `reset_count` stays 0.
- Accepted load of 07:15 coincident with `one_minute` → 07:15 (no increment); `reset_count` high during the following cycle only.
- 1440 consecutive `one_minute` cycles from 00:00 → back to 00:00, exactly one `day_tick`.
- With `ACLK_TCNT_SECONDS_EN`: 59 `one_second` pulses → `cur_s` = 59; next `one_second` → 00, minutes unchanged; `one_minute` at seconds 30 → seconds 00, minutes +1.
